// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one request/acknowledge memory port between the
// instruction fetch path and the load/store path, with a bounded ACK wait.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            CLK,
    input  logic            RES_N,
    input  logic            IF_REQ,
    input  logic [AW-1:0]   IF_ADDR,
    output logic            IF_VALID,
    output logic [DW-1:0]   IF_RDATA,
    input  logic            D_REQ,
    input  logic            D_WE,
    input  logic [AW-1:0]   D_ADDR,
    input  logic [DW-1:0]   D_WDATA,
    input  logic [DW/8-1:0] D_BE,
    output logic            D_VALID,
    output logic [DW-1:0]   D_RDATA,
    output logic            ERR,
    output logic            MEM_REQ,
    output logic            MEM_WE,
    output logic [AW-1:0]   MEM_ADDR,
    output logic [DW-1:0]   MEM_WDATA,
    output logic [DW/8-1:0] MEM_BE,
    input  logic            MEM_ACK,
    input  logic [DW-1:0]   MEM_RDATA
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       last_d_q;
    logic [7:0] wait_cnt_q;
    logic       grant_i;
    logic       grant_d;
    logic       acked;
    logic       timed_out;

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // On a tie the requester that was not served last wins.
    always_comb begin
        state_d   = state_q;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        acked     = 1'b0;
        timed_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (IF_REQ && (!D_REQ || last_d_q)) begin
                    grant_i = 1'b1;
                    state_d = BUSY_I;
                end else if (D_REQ) begin
                    grant_d = 1'b1;
                    state_d = BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                if (MEM_ACK) begin
                    acked   = 1'b1;
                    state_d = RESP;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timed_out = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            last_d_q   <= 1'b1;
            wait_cnt_q <= '0;
            MEM_REQ    <= 1'b0;
            MEM_WE     <= 1'b0;
            MEM_ADDR   <= '0;
            MEM_WDATA  <= '0;
            MEM_BE     <= '0;
            IF_VALID   <= 1'b0;
            IF_RDATA   <= '0;
            D_VALID    <= 1'b0;
            D_RDATA    <= '0;
            ERR        <= 1'b0;
        end else begin
            if (grant_i || grant_d) begin
                MEM_REQ    <= 1'b1;
                wait_cnt_q <= '0;
                if (IF_REQ && D_REQ) begin
                    last_d_q <= grant_d;
                end
                if (grant_i) begin
                    MEM_WE    <= 1'b0;
                    MEM_ADDR  <= IF_ADDR;
                    MEM_WDATA <= '0;
                    MEM_BE    <= '1;
                end else begin
                    MEM_WE    <= D_WE;
                    MEM_ADDR  <= D_ADDR;
                    MEM_WDATA <= D_WDATA;
                    MEM_BE    <= D_BE;
                end
            end

            if ((state_q == BUSY_I || state_q == BUSY_D) && !acked && !timed_out) begin
                wait_cnt_q <= wait_cnt_q + 8'd1;
            end

            // Completion: response registers are loaded here so they show in RESP.
            if (acked || timed_out) begin
                MEM_REQ <= 1'b0;
                ERR     <= timed_out;
                if (state_q == BUSY_I) begin
                    IF_VALID <= 1'b1;
                    if (acked) begin
                        IF_RDATA <= MEM_RDATA;
                    end
                end else begin
                    D_VALID <= 1'b1;
                    if (acked && !MEM_WE) begin
                        D_RDATA <= MEM_RDATA;
                    end
                end
            end

            if (state_q == RESP) begin
                IF_VALID <= 1'b0;
                D_VALID  <= 1'b0;
                ERR      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester drivers push expected responses,
// a negedge monitor checks grants, MEM_* stability and the returned responses.
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic          CLK = 1'b0;
    logic          RES_N = 1'b0;
    logic          IF_REQ = 1'b0;
    logic [AW-1:0] IF_ADDR = '0;
    logic          IF_VALID;
    logic [DW-1:0] IF_RDATA;
    logic          D_REQ = 1'b0;
    logic          D_WE = 1'b0;
    logic [AW-1:0] D_ADDR = '0;
    logic [DW-1:0] D_WDATA = '0;
    logic [3:0]    D_BE = '0;
    logic          D_VALID;
    logic [DW-1:0] D_RDATA;
    logic          ERR;
    logic          MEM_REQ;
    logic          MEM_WE;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_WDATA;
    logic [3:0]    MEM_BE;
    logic          MEM_ACK = 1'b0;
    logic [DW-1:0] MEM_RDATA = '0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RES_N(RES_N),
        .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_VALID(IF_VALID), .IF_RDATA(IF_RDATA),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA), .D_BE(D_BE),
        .D_VALID(D_VALID), .D_RDATA(D_RDATA), .ERR(ERR),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_BE(MEM_BE), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } rsp_t;

    rsp_t        if_exp_q[$];
    rsp_t        d_exp_q[$];
    bit          grant_q[$];
    logic [31:0] mem[logic [31:0]];
    logic [31:0] if_model = '0;
    logic [31:0] d_model = '0;
    int          ack_lat = 0;

    function automatic logic [31:0] lookup(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic bit is_dead(input logic [31:0] a);
        return a[31:28] == 4'hF;
    endfunction

    // Monitor and memory responder share one process to keep ordering fixed.
    int          cyc = 0, rise_cyc = 0, last_rise = 0, wait_n = 0, cur_lat = 0;
    bit          prev_req = 0, cur_g = 0, gap_en = 0, have_last = 0;
    logic        hold_we;
    logic [3:0]  hold_be;
    logic [31:0] hold_addr, hold_wdata, w_tmp;
    rsp_t        e;

    always @(negedge CLK) begin
        cyc++;
        if (!RES_N) begin
            prev_req = 0;
            wait_n   = 0;
            MEM_ACK  = 1'b0;
        end else begin
            if (MEM_REQ && !prev_req) begin
                rise_cyc = cyc;
                wait_n   = 0;
                cur_lat  = ack_lat;
                if (gap_en && have_last) check("grant_gap", cyc - last_rise, 3);
                last_rise = cyc;
                have_last = 1;
                if (grant_q.size() == 0) begin
                    check("grant_unexpected", 1, 0);
                end else begin
                    cur_g = grant_q.pop_front();
                    if (!cur_g) begin
                        check("if_mem_we", MEM_WE, 0);
                        check("if_mem_addr", MEM_ADDR, IF_ADDR);
                        check("if_mem_be", MEM_BE, 4'hF);
                    end else begin
                        check("d_mem_we", MEM_WE, D_WE);
                        check("d_mem_addr", MEM_ADDR, D_ADDR);
                        check("d_mem_be", MEM_BE, D_BE);
                        if (D_WE) check("d_mem_wdata", MEM_WDATA, D_WDATA);
                    end
                end
                hold_we = MEM_WE; hold_be = MEM_BE; hold_addr = MEM_ADDR; hold_wdata = MEM_WDATA;
            end else if (MEM_REQ) begin
                check("mem_hold_ctl", {MEM_WE, MEM_BE, MEM_ADDR}, {hold_we, hold_be, hold_addr});
                check("mem_hold_wdata", MEM_WDATA, hold_wdata);
            end

            if (MEM_REQ) begin
                if (!is_dead(MEM_ADDR) && wait_n == cur_lat) begin
                    MEM_ACK = 1'b1;
                    if (MEM_WE) begin
                        w_tmp = lookup(MEM_ADDR);
                        for (int b = 0; b < 4; b++)
                            if (MEM_BE[b]) w_tmp[8*b +: 8] = MEM_WDATA[8*b +: 8];
                        mem[MEM_ADDR] = w_tmp;
                        MEM_RDATA = $urandom;
                    end else begin
                        MEM_RDATA = lookup(MEM_ADDR);
                    end
                end else begin
                    MEM_ACK   = 1'b0;
                    MEM_RDATA = $urandom;
                end
                wait_n++;
            end else begin
                // Stray ACKs outside an access must be ignored.
                MEM_ACK   = 1'($urandom_range(0, 1));
                MEM_RDATA = $urandom;
            end

            if (IF_VALID || D_VALID) begin
                check("valid_owner", {IF_VALID, D_VALID}, cur_g ? 2'b01 : 2'b10);
                check("valid_mem_req", MEM_REQ, 0);
                if (IF_VALID) begin
                    if (if_exp_q.size() == 0) begin
                        check("if_valid_unexpected", 1, 0);
                    end else begin
                        e = if_exp_q.pop_front();
                        check("if_rdata", IF_RDATA, e.rdata);
                        check("if_err", ERR, e.err);
                        check("if_latency", cyc - rise_cyc, e.lat);
                    end
                end
                if (D_VALID) begin
                    if (d_exp_q.size() == 0) begin
                        check("d_valid_unexpected", 1, 0);
                    end else begin
                        e = d_exp_q.pop_front();
                        check("d_rdata", D_RDATA, e.rdata);
                        check("d_err", ERR, e.err);
                        check("d_latency", cyc - rise_cyc, e.lat);
                    end
                end
            end
            prev_req = MEM_REQ;
        end
    end

    // Fetch requester; 'early' is shown on IF_ADDR until wait cycle swap_after.
    task automatic do_fetch(input logic [31:0] a, input logic [31:0] early, input int swap_after);
        rsp_t r;
        bit   seen = 0;
        r.err   = is_dead(a);
        r.lat   = r.err ? TMO : ack_lat + 1;
        r.rdata = r.err ? if_model : lookup(a);
        if_model = r.rdata;
        if_exp_q.push_back(r);
        @(negedge CLK);
        IF_ADDR = (swap_after > 0) ? early : a;
        IF_REQ  = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (IF_VALID) begin
                seen = 1;
                break;
            end
            if (swap_after > 0 && i == swap_after) IF_ADDR = a;
        end
        if (!seen) check("if_wait_timeout", 0, 1);
        IF_REQ = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be);
        rsp_t r;
        bit   seen = 0;
        r.err   = is_dead(a);
        r.lat   = r.err ? TMO : ack_lat + 1;
        r.rdata = (we || r.err) ? d_model : lookup(a);
        d_model = r.rdata;
        d_exp_q.push_back(r);
        @(negedge CLK);
        D_WE = we; D_ADDR = a; D_WDATA = wd; D_BE = be;
        D_REQ = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (D_VALID) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check("d_wait_timeout", 0, 1);
        D_REQ = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;

        // Reset held with both requesters active, then continuous contention.
        for (int k = 0; k < 3; k++) begin
            grant_q.push_back(1'b0);
            grant_q.push_back(1'b1);
        end
        gap_en = 1; have_last = 0; ack_lat = 0;
        fork
            begin
                repeat (3) @(negedge CLK);
                check("rst_mem_ctl", {MEM_REQ, MEM_WE, MEM_BE, MEM_ADDR}, 0);
                check("rst_mem_wdata", MEM_WDATA, 0);
                check("rst_if", {IF_VALID, IF_RDATA}, 0);
                check("rst_d", {D_VALID, D_RDATA, ERR}, 0);
                #2 RES_N = 1'b1;
            end
            begin
                for (int k = 0; k < 3; k++) do_fetch(32'h200 + 32'(4*k), 32'h0, 0);
            end
            begin
                for (int k = 0; k < 3; k++) do_data(1'b0, 32'h3000 + 32'(4*k), 32'h0, 4'hF);
            end
        join
        gap_en = 0;

        // Single fetch with immediate ACK.
        mem[32'h100] = 32'h00A00093;
        grant_q.push_back(1'b0);
        do_fetch(32'h100, 32'h0, 0);

        // Store with a slow memory, then read it back through a load.
        ack_lat = 5;
        grant_q.push_back(1'b1);
        do_data(1'b1, 32'h2004, 32'hDEADBEEF, 4'b0011);
        ack_lat = 2;
        grant_q.push_back(1'b1);
        do_data(1'b0, 32'h2004, 32'h0, 4'b0101);

        // Timed-out load while a fetch waits and moves its address.
        ack_lat = 0;
        grant_q.push_back(1'b1);
        grant_q.push_back(1'b0);
        fork
            do_data(1'b0, 32'hF000_0010, 32'h0, 4'hF);
            begin
                repeat (2) @(negedge CLK);
                do_fetch(32'h404, 32'h400, 3);
            end
        join

        // Reset during a data access abandons it.
        grant_q.push_back(1'b1);
        @(negedge CLK);
        D_WE = 1'b1; D_ADDR = 32'hF000_0020; D_WDATA = 32'h12345678; D_BE = 4'hF;
        D_REQ = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (MEM_REQ) begin
                seen = 1;
                break;
            end
        end
        check("midrst_req_seen", seen, 1);
        repeat (2) @(negedge CLK);
        #2 RES_N = 1'b0;
        D_REQ = 1'b0;
        #1;
        check("midrst_mem_req", MEM_REQ, 0);
        check("midrst_valid", {IF_VALID, D_VALID, D_RDATA}, 0);
        if_model = '0;
        d_model  = '0;
        repeat (3) @(negedge CLK);
        #2 RES_N = 1'b1;
        repeat (2) @(negedge CLK);
        grant_q.push_back(1'b0);
        do_fetch(32'h500, 32'h0, 0);

        repeat (5) @(negedge CLK);
        check("grant_q_drained", grant_q.size(), 0);
        check("if_q_drained", if_exp_q.size(), 0);
        check("d_q_drained", d_exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
